// File: rtl/dcache_refill_unit_if.sv
// rtl/dcache_refill_unit_if.sv - handshake/bus bundle for the dcache refill engine
// Groups the miss-handler request, the memory AR/R channels, the data bank
// write port and the completion/status signals.
//   slave  : view of the refill engine
//   master : view of the surrounding miss handler, memory and bank array
interface dcache_refill_unit_if #(
  parameter int NBANKS = 4,
  parameter int SET_W  = 6,
  parameter int WAYS   = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_W-1:0]     req_addr;
  logic [WAYS-1:0]       req_way;

  logic                  mem_ar_valid;
  logic                  mem_ar_ready;
  logic [ADDR_W-1:0]     mem_ar_addr;
  logic [7:0]            mem_ar_len;

  logic                  mem_r_valid;
  logic                  mem_r_ready;
  logic [DATA_W-1:0]     mem_r_data;
  logic                  mem_r_last;

  logic [NBANKS-1:0]     bank_w_en;
  logic [SET_W-1:0]      bank_w_set;
  logic [WAYS-1:0]       bank_w_way;
  logic [DATA_W-1:0]     bank_w_data;
  logic [DATA_W/8-1:0]   bank_w_mask;

  logic                  done;
  logic                  done_err;
  logic                  busy;

  modport slave (
    input  req_valid, req_addr, req_way,
    output req_ready,
    output mem_ar_valid, mem_ar_addr, mem_ar_len,
    input  mem_ar_ready,
    input  mem_r_valid, mem_r_data, mem_r_last,
    output mem_r_ready,
    output bank_w_en, bank_w_set, bank_w_way, bank_w_data, bank_w_mask,
    output done, done_err, busy
  );

  modport master (
    output req_valid, req_addr, req_way,
    input  req_ready,
    input  mem_ar_valid, mem_ar_addr, mem_ar_len,
    output mem_ar_ready,
    output mem_r_valid, mem_r_data, mem_r_last,
    input  mem_r_ready,
    input  bank_w_en, bank_w_set, bank_w_way, bank_w_data, bank_w_mask,
    input  done, done_err, busy
  );
endinterface

// File: rtl/dcache_refill_unit.sv
// rtl/dcache_refill_unit.sv - cache-line refill engine feeding the per-way data banks
// Accepts a refill request, issues one burst read of NBANKS beats and writes
// beat i into bank i of the latched set/way one cycle after it is accepted.
//   clock, reset : clock and asynchronous active-low reset
//   bus (slave)  : request, memory AR/R, bank write port, done/done_err/busy
module dcache_refill_unit #(
  parameter int NBANKS = 4,
  parameter int SET_W  = 6,
  parameter int WAYS   = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  dcache_refill_unit_if.slave  bus
);

  localparam int OFF   = $clog2(NBANKS) + 2;
  localparam int IDX_W = (NBANKS > 1) ? $clog2(NBANKS) : 1;
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_RECV,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [SET_W-1:0]    set_q, set_d;
  logic [WAYS-1:0]     way_q, way_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                wr_pend_q, wr_pend_d;
  logic [IDX_W-1:0]    wr_idx_q, wr_idx_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;

  // Byte-offset and bank-select bits of the miss address are discarded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.req_addr[OFF-1:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      set_q     <= '0;
      way_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      wr_pend_q <= 1'b0;
      wr_idx_q  <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      set_q     <= set_d;
      way_q     <= way_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      wr_pend_q <= wr_pend_d;
      wr_idx_q  <= wr_idx_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    set_d     = set_q;
    way_d     = way_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    // The write register holds a beat for exactly one cycle.
    wr_pend_d = 1'b0;
    wr_idx_d  = wr_idx_q;
    wr_data_d = wr_data_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          addr_d  = {bus.req_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
          set_d   = bus.req_addr[SET_W+OFF-1:OFF];
          way_d   = bus.req_way;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (bus.mem_ar_ready) state_d = S_RECV;
      end
      S_RECV: begin
        if (bus.mem_r_valid) begin
          if (cnt_q < CNT_W'(NBANKS)) begin
            wr_pend_d = 1'b1;
            wr_idx_d  = cnt_q[IDX_W-1:0];
            wr_data_d = bus.mem_r_data;
            cnt_d     = cnt_q + CNT_W'(1);
          end else begin
            // Counter saturated: beat is dropped and the refill is flagged.
            err_d = 1'b1;
          end
          if (bus.mem_r_last) begin
            state_d = S_FLUSH;
            if ((cnt_q + CNT_W'(1)) != CNT_W'(NBANKS)) err_d = 1'b1;
          end
        end
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  logic [NBANKS-1:0] bank_one_hot;
  assign bank_one_hot = {{(NBANKS-1){1'b0}}, 1'b1} << wr_idx_q;

  assign bus.req_ready    = (state_q == S_IDLE);
  assign bus.mem_ar_valid = (state_q == S_ADDR);
  assign bus.mem_ar_addr  = addr_q;
  // Length is only driven while the request is offered so every output is 0 in reset.
  assign bus.mem_ar_len   = (state_q == S_ADDR) ? 8'(NBANKS - 1) : 8'd0;
  assign bus.mem_r_ready  = (state_q == S_RECV);

  // Async reset clears wr_pend_q, which removes the enable immediately.
  assign bus.bank_w_en    = wr_pend_q ? bank_one_hot : '0;
  assign bus.bank_w_set   = set_q;
  assign bus.bank_w_way   = way_q;
  assign bus.bank_w_data  = wr_data_q;
  assign bus.bank_w_mask  = {(DATA_W/8){wr_pend_q}};

  assign bus.done         = (state_q == S_DONE);
  assign bus.done_err     = (state_q == S_DONE) && err_q;
  assign bus.busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_dcache_refill_unit.sv
// tb/tb_dcache_refill_unit.sv - scoreboard testbench for dcache_refill_unit
module tb_dcache_refill_unit;
  localparam int NBANKS = 4;
  localparam int SET_W  = 6;
  localparam int WAYS   = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  dcache_refill_unit_if #(.NBANKS(NBANKS), .SET_W(SET_W), .WAYS(WAYS),
                          .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  dcache_refill_unit #(.NBANKS(NBANKS), .SET_W(SET_W), .WAYS(WAYS),
                       .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  en;
    logic [31:0] data;
    logic [5:0]  set;
    logic [3:0]  way;
    int          wcyc;
  } wr_t;

  wr_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  int  writes_seen = 0;
  int  done_seen   = 0;
  int  exp_cnt     = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor: every bank write must match the oldest expected beat.
  always @(negedge clock) begin : mon
    wr_t e;
    if (reset) begin
      if (bus.done) done_seen++;
      if (bus.bank_w_en != '0) begin
        writes_seen++;
        if (exp_q.size() == 0) begin
          check_eq("unexpected_write", 64'(bus.bank_w_en), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check_eq("w_en",    64'(bus.bank_w_en),   64'(e.en));
          check_eq("w_data",  64'(bus.bank_w_data), 64'(e.data));
          check_eq("w_set",   64'(bus.bank_w_set),  64'(e.set));
          check_eq("w_way",   64'(bus.bank_w_way),  64'(e.way));
          check_eq("w_mask",  64'(bus.bank_w_mask), 64'(4'hF));
          check_eq("w_cycle", 64'(cyc),             64'(e.wcyc));
        end
      end
    end
  end

  task automatic send_req(input logic [31:0] addr, input logic [3:0] way, input bit hold);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_way   = way;
    check_eq("req_ready_idle", 64'(bus.req_ready), 64'(1));
    @(negedge clock);
    if (!hold) bus.req_valid = 1'b0;
    check_eq("busy_after_req", 64'(bus.busy), 64'(1));
    check_eq("req_ready_busy", 64'(bus.req_ready), 64'(0));
  endtask

  task automatic do_addr(input logic [31:0] exp_addr, input int stall);
    bus.mem_ar_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      check_eq("ar_valid_stall", 64'(bus.mem_ar_valid), 64'(1));
      check_eq("ar_addr_stall",  64'(bus.mem_ar_addr),  64'(exp_addr));
      @(negedge clock);
    end
    bus.mem_ar_ready = 1'b1;
    check_eq("ar_valid", 64'(bus.mem_ar_valid), 64'(1));
    check_eq("ar_addr",  64'(bus.mem_ar_addr),  64'(exp_addr));
    check_eq("ar_len",   64'(bus.mem_ar_len),   64'(NBANKS - 1));
    @(negedge clock);
    bus.mem_ar_ready = 1'b0;
    check_eq("ar_valid_drop", 64'(bus.mem_ar_valid), 64'(0));
    check_eq("r_ready_recv",  64'(bus.mem_r_ready),  64'(1));
  endtask

  task automatic send_beat(input logic [31:0] data, input bit last,
                           input logic [5:0] set, input logic [3:0] way);
    int t;
    wr_t e;
    t = 0;
    bus.mem_r_valid = 1'b1;
    bus.mem_r_data  = data;
    bus.mem_r_last  = last;
    while (!bus.mem_r_ready && t < 20) begin
      @(negedge clock);
      t++;
    end
    check_eq("beat_ready_timeout", 64'(t < 20), 64'(1));
    if (exp_cnt < NBANKS) begin
      e.en   = 4'(1 << exp_cnt);
      e.data = data;
      e.set  = set;
      e.way  = way;
      e.wcyc = cyc + 1;
      exp_q.push_back(e);
    end
    exp_cnt++;
    @(negedge clock);
    bus.mem_r_valid = 1'b0;
    bus.mem_r_last  = 1'b0;
  endtask

  task automatic do_refill(input logic [31:0] addr, input logic [3:0] way, input int nbeats,
                           input int ar_stall, input int gap, input bit hold,
                           input logic [31:0] next_addr, input bit exp_err,
                           input logic [31:0] dbase);
    logic [5:0] set;
    int w0, t, nw;
    set     = addr[9:4];
    exp_cnt = 0;
    w0      = writes_seen;
    send_req(addr, way, hold);
    if (hold) bus.req_addr = next_addr;
    do_addr(addr & 32'hFFFF_FFF0, ar_stall);
    for (int i = 0; i < nbeats; i++) begin
      if (i > 0) repeat (gap) @(negedge clock);
      send_beat(dbase + 32'(i), (i == nbeats - 1), set, way);
    end
    t = 0;
    while (!bus.done && t < 10) begin
      @(negedge clock);
      t++;
    end
    check_eq("done_timeout", 64'(t < 10), 64'(1));
    check_eq("done_err", 64'(bus.done_err), 64'(exp_err));
    check_eq("req_ready_in_done", 64'(bus.req_ready), 64'(0));
    @(negedge clock);
    check_eq("done_one_cycle", 64'(bus.done), 64'(0));
    check_eq("idle_req_ready", 64'(bus.req_ready), 64'(1));
    check_eq("idle_busy", 64'(bus.busy), 64'(0));
    nw = (nbeats < NBANKS) ? nbeats : NBANKS;
    check_eq("write_count", 64'(writes_seen - w0), 64'(nw));
    check_eq("queue_drained", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    bus.req_valid    = 1'b0;
    bus.req_addr     = '0;
    bus.req_way      = '0;
    bus.mem_ar_ready = 1'b0;
    bus.mem_r_valid  = 1'b0;
    bus.mem_r_data   = '0;
    bus.mem_r_last   = 1'b0;

    repeat (2) @(negedge clock);
    check_eq("rst_req_ready", 64'(bus.req_ready),    64'(1));
    check_eq("rst_busy",      64'(bus.busy),         64'(0));
    check_eq("rst_ar_valid",  64'(bus.mem_ar_valid), 64'(0));
    check_eq("rst_r_ready",   64'(bus.mem_r_ready),  64'(0));
    check_eq("rst_w_en",      64'(bus.bank_w_en),    64'(0));
    check_eq("rst_done",      64'(bus.done),         64'(0));
    check_eq("rst_ar_addr",   64'(bus.mem_ar_addr),  64'(0));
    check_eq("rst_mask",      64'(bus.bank_w_mask),  64'(0));
    reset = 1'b1;
    @(negedge clock);

    // basic refill
    do_refill(32'h0000_1234, 4'b0100, 4, 0, 0, 1'b0, 32'h0, 1'b0, 32'hA0);
    // stalled AR and gapped beats
    do_refill(32'h0000_8ABC, 4'b0001, 4, 5, 2, 1'b0, 32'h0, 1'b0, 32'h5500);
    // early last
    do_refill(32'h0001_0FF8, 4'b1000, 2, 1, 0, 1'b0, 32'h0, 1'b1, 32'hE000);
    // overrun
    do_refill(32'hDEAD_BEE4, 4'b0010, 6, 0, 1, 1'b0, 32'h0, 1'b1, 32'h0600);

    // reset after beat 2 accepted
    exp_cnt = 0;
    d0 = done_seen;
    send_req(32'h0000_3340, 4'b0010, 1'b0);
    do_addr(32'h0000_3340, 0);
    send_beat(32'h7000, 1'b0, 6'h34, 4'b0010);
    send_beat(32'h7001, 1'b0, 6'h34, 4'b0010);
    bus.mem_r_valid = 1'b1;
    bus.mem_r_data  = 32'h7002;
    @(posedge clock);
    #2 reset = 1'b0;
    bus.mem_r_valid = 1'b0;
    #1;
    check_eq("rst_mid_w_en",      64'(bus.bank_w_en),  64'(0));
    check_eq("rst_mid_busy",      64'(bus.busy),       64'(0));
    check_eq("rst_mid_req_ready", 64'(bus.req_ready),  64'(1));
    repeat (3) @(negedge clock);
    check_eq("rst_mid_no_done", 64'(done_seen - d0), 64'(0));
    check_eq("rst_mid_queue",   64'(exp_q.size()),   64'(0));
    reset = 1'b1;
    @(negedge clock);
    do_refill(32'h0000_3340, 4'b0010, 4, 0, 0, 1'b0, 32'h0, 1'b0, 32'h7100);

    // back-to-back requests with req_valid held high
    do_refill(32'h0000_0400, 4'b0001, 4, 0, 0, 1'b1, 32'h0000_0810, 1'b0, 32'h9000);
    do_refill(32'h0000_0810, 4'b1000, 4, 2, 0, 1'b0, 32'h0, 1'b0, 32'h9100);

    repeat (2) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dcache_refill_unit.md
Name: dcache_refill_unit

Overview:
- Cache-line refill engine sitting directly upstream of the per-way data bank array; it writes refill data into the banks.
- On a miss it accepts a refill request, issues one burst read to memory, and collects NBANKS beats.
- Each beat is written into bank i (beat i) of the selected way and set, with a full byte mask.
- Signals completion to the miss handler with a one-cycle done pulse.

Parameters:
NBANKS, 4, words per line; one bank per word; power of two
SET_W, 6, set index width
WAYS, 4, number of ways; way select is one-hot
DATA_W, 32, beat/bank word width
ADDR_W, 32, physical address width

Ports:
clock  in  1  single clock
reset  in  1  asynchronous, active-low reset
req_valid  in  1  refill request valid
req_ready  out  1  high only in IDLE
req_addr  in  ADDR_W  miss address (any offset)
req_way  in  WAYS  one-hot victim way
mem_ar_valid  out  1  burst read request valid
mem_ar_ready  in  1  memory accepts request
mem_ar_addr  out  ADDR_W  line-aligned address (low log2(NBANKS)+2 bits zero)
mem_ar_len  out  8  burst length minus one, constant NBANKS-1
mem_r_valid  in  1  read beat valid
mem_r_ready  out  1  high only in RECV
mem_r_data  in  DATA_W  read beat data
mem_r_last  in  1  final beat marker
bank_w_en  out  NBANKS  per-bank write enable, at most one bit high
bank_w_set  out  SET_W  set index = req_addr[SET_W+OFF-1:OFF], OFF=log2(NBANKS)+2
bank_w_way  out  WAYS  latched req_way
bank_w_data  out  DATA_W  beat data
bank_w_mask  out  DATA_W/8  all ones during a write
done  out  1  one-cycle completion pulse
done_err  out  1  valid with done; beat count did not equal NBANKS
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE; beat counter=0; err flag=0; pending write dropped.
  - All outputs 0, except req_ready=1.
  - Reset during any state aborts the refill; no further bank writes are issued.
- States: IDLE, ADDR, RECV, FLUSH, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid, latch the line-aligned address, set and way; clear the counter and err flag; go to ADDR.
- ADDR:
  - mem_ar_valid=1, with addr and len held stable until accepted.
  - On mem_ar_ready, go to RECV. Same-cycle acceptance of the request is allowed.
- RECV:
  - mem_r_ready=1.
  - Each accepted beat (valid&ready) is captured into a write register.
  - In the next cycle, bank_w_en[idx]=1 with idx = beat counter at capture time, plus data, set, way and full mask. Latency is exactly 1 cycle from beat acceptance to bank write.
  - Counter increments per beat and saturates at NBANKS.
  - A beat arriving when counter==NBANKS is not written and sets err.
  - Back-to-back beats produce back-to-back writes to consecutive banks.
  - On an accepted beat with mem_r_last=1, go to FLUSH. If counter+1 != NBANKS, set err.
  - Early last: remaining banks are not written.
- FLUSH:
  - Issues the final registered write (exactly one cycle), then goes to DONE.
- DONE:
  - done=1 and done_err=err for exactly one cycle, then IDLE.
  - req_ready stays 0 in DONE; a new request is accepted at the earliest in the following IDLE cycle.
- bank_w_en is 0 in every cycle that has no write, and other bank_w_* values are don't-care then.
- mem_r_ready=0 outside RECV; beats arriving outside RECV are ignored.
- req_way is not checked for one-hot; it is passed through as given.
- Throughput: minimum refill = 1 (ADDR) + NBANKS (RECV) + 1 (FLUSH) + 1 (DONE) cycles after the request handshake.

Test Plan:
- Basic refill:
  - Stimulus: req_addr=0x0000_1234, req_way=4'b0100, ar_ready immediate, 4 beats 0xA0..0xA3 back-to-back, last on beat 3.
  - Required: mem_ar_addr=0x0000_1230, len=3, bank_w_set=0x23, way=0100, bank_w_en 0001,0010,0100,1000 on consecutive cycles each one cycle after its beat, mask=1111, done pulse, done_err=0.
- Stalled handshakes:
  - Stimulus: ar_ready held low 5 cycles; r_valid gaps of 2 cycles between beats.
  - Required: ar_addr stable while waiting; exactly 4 writes, each 1 cycle after its accepted beat; no writes in gap cycles.
- Early last:
  - Stimulus: last asserted on beat 1.
  - Required: writes only to banks 0 and 1, done_err=1.
- Overrun:
  - Stimulus: 6 beats, last on beat 5.
  - Required: banks 0..3 written once each, beats 4-5 dropped, done_err=1.
- Reset mid-refill:
  - Stimulus: reset low after beat 2 is accepted.
  - Required: bank_w_en=0 immediately (asynchronously), no done pulse, req_ready=1, busy=0; a subsequent refill completes normally.
- Back-to-back requests:
  - Stimulus: req_valid held high with a second address.
  - Required: second request accepted in the IDLE cycle after the done pulse; no overlap of AR or writes between the two refills.
